// File: rtl/op_dispatcher_if.sv
// rtl/op_dispatcher_if.sv - op type and op/valid/ready stream interface
package op_dispatcher_pkg;
    typedef struct packed {
        logic [7:0]  code;
        logic [15:0] x;
        logic [15:0] y;
    } Op_st;
endpackage

interface op_dispatcher_if;
    import op_dispatcher_pkg::*;
    Op_st tdata;
    logic tvalid;
    logic tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/op_dispatcher.sv
// rtl/op_dispatcher.sv - buffers parser ops and issues them one at a time to the processor
module op_dispatcher
    import op_dispatcher_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clk_en,
    op_dispatcher_if.slave           s_in,
    op_dispatcher_if.master          m_proc,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_err,
    input  logic                     i_err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    Op_st            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    Op_st            r_op;
    logic            r_trigger;
    logic            r_err;
    logic [TW-1:0]   r_tmo;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_trigger_nxt;
    logic            w_err_nxt;
    logic [TW-1:0]   w_tmo_nxt;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0) && m_proc.tready;
    // A full FIFO still takes a push in the cycle its head is popped.
    assign w_push = s_in.tvalid && (!w_full || w_pop);

    assign s_in.tready   = !w_full || w_pop;
    assign m_proc.tdata  = r_op;
    assign m_proc.tvalid = r_trigger;
    assign o_count       = r_count;
    assign o_err         = r_err;
    assign o_busy        = (r_count != '0) || (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_trigger_nxt = r_trigger;
        w_err_nxt     = r_err;
        w_tmo_nxt     = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt   = ST_ISSUE;
                    w_trigger_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                if (!m_proc.tready) begin
                    w_state_nxt   = ST_WAIT_DONE;
                    w_trigger_nxt = 1'b0;
                end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt   = ST_ERROR;
                    w_trigger_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (m_proc.tready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (i_err_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_trigger_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_op      <= '0;
            r_trigger <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= '0;
        end else if (i_clk_en) begin
            r_state   <= w_state_nxt;
            r_trigger <= w_trigger_nxt;
            r_err     <= w_err_nxt;
            r_tmo     <= w_tmo_nxt;
            if (w_pop) begin
                r_op     <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && w_push) begin
            r_mem[r_wr_ptr] <= s_in.tdata;
        end
    end
endmodule

// File: tb/tb_op_dispatcher.sv
// tb/tb_op_dispatcher.sv - randomized and directed bench for op_dispatcher
module tb_op_dispatcher;
    import op_dispatcher_pkg::*;

    localparam int DEPTH = 4;
    localparam int ACK   = 24;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_ERR = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic          err_clr;
    logic          busy;
    logic          err;
    logic [CW-1:0] count;

    op_dispatcher_if in_if ();
    op_dispatcher_if pr_if ();

    always #5 clk = ~clk;

    op_dispatcher #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (
        .i_clk     (clk),
        .i_reset   (reset_n),
        .i_clk_en  (clk_en),
        .s_in      (in_if),
        .m_proc    (pr_if),
        .o_busy    (busy),
        .o_count   (count),
        .o_err     (err),
        .i_err_clr (err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending ops plus the handshake phase.
    Op_st m_q[$];
    int   m_ph;
    Op_st m_op;
    bit   m_trig;
    bit   m_err;
    int   m_tmo;
    bit   m_acc;

    function automatic Op_st mk(input int c, input int x, input int y);
        Op_st o;
        o.code = 8'(c);
        o.x    = 16'(x);
        o.y    = 16'(y);
        return o;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ph   = P_IDLE;
        m_op   = '0;
        m_trig = 1'b0;
        m_err  = 1'b0;
        m_tmo  = 0;
    endtask

    task automatic model_step();
        bit rdy, pop, push;
        rdy  = pr_if.tready;
        pop  = (m_ph == P_IDLE) && (m_q.size() > 0) && rdy;
        push = in_if.tvalid && ((m_q.size() < DEPTH) || pop);
        case (m_ph)
            P_IDLE:  if (pop) begin m_ph = P_ISSUE; m_trig = 1'b1; m_tmo = 0; end
            P_ISSUE: begin
                if (!rdy) begin
                    m_ph = P_WAIT; m_trig = 1'b0;
                end else begin
                    m_tmo++;
                    if (m_tmo == ACK) begin m_ph = P_ERR; m_trig = 1'b0; m_err = 1'b1; end
                end
            end
            P_WAIT:  if (rdy) m_ph = P_IDLE;
            default: if (err_clr) begin m_ph = P_IDLE; m_err = 1'b0; end
        endcase
        if (pop)  m_op = m_q.pop_front();
        if (push) m_q.push_back(in_if.tdata);
        m_acc = push;
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = (m_q.size() < DEPTH) || ((m_ph == P_IDLE) && (m_q.size() > 0) && pr_if.tready);
        chk("count",   64'(count),        64'(m_q.size()));
        chk("trigger", 64'(pr_if.tvalid), 64'(m_trig));
        chk("op",      64'(pr_if.tdata),  64'(m_op));
        chk("err",     64'(err),          64'(m_err));
        chk("busy",    64'(busy),         64'((m_q.size() != 0) || (m_ph != P_IDLE)));
        chk("in_rdy",  64'(in_if.tready), 64'(exp_rdy));
    endtask

    // Processor responder and bookkeeping
    int   en_mode = 0;
    bit   p_hold = 0, p_never = 0;
    int   p_ack = 3, p_done = 20, p_cnt = 0;
    int   tick_n = 0, trig_hi = 0;
    int   rdy_rise_t = 0, busy_fall_t = 0, trig_rise_t = 0, err_rise_t = 0;
    bit   prev_busy = 0, prev_trig = 0, prev_err = 0;
    Op_st issued[$];

    task automatic tick();
        bit en_was;
        case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = ~clk_en;
            default: clk_en = 1'($urandom_range(0, 1));
        endcase
        en_was = clk_en;
        if (en_was) model_step(); else m_acc = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        tick_n++;
        if (pr_if.tvalid) trig_hi++;
        if (pr_if.tvalid && !prev_trig) begin
            trig_rise_t = tick_n;
            issued.push_back(pr_if.tdata);
        end
        if (prev_busy && !busy) busy_fall_t = tick_n;
        if (err && !prev_err) err_rise_t = tick_n;
        prev_busy = busy;
        prev_trig = pr_if.tvalid;
        prev_err  = err;
        if (!p_hold && en_was) begin
            if (pr_if.tready) begin
                if (pr_if.tvalid && !p_never) begin
                    p_cnt++;
                    if (p_cnt >= p_ack) begin pr_if.tready = 1'b0; p_cnt = 0; end
                end else begin
                    p_cnt = 0;
                end
            end else begin
                p_cnt++;
                if (p_cnt >= p_done) begin
                    pr_if.tready = 1'b1; p_cnt = 0; rdy_rise_t = tick_n;
                end
            end
        end
    endtask

    task automatic push(input Op_st o);
        in_if.tvalid = 1'b1;
        in_if.tdata  = o;
        m_acc = 1'b0;
        for (int i = 0; i < 50 && !m_acc; i++) tick();
        in_if.tvalid = 1'b0;
        chk("push_accepted", 64'(m_acc), 64'(1));
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && ((m_q.size() != 0) || (m_ph != P_IDLE)); i++) tick();
        chk("drain_busy", 64'(busy), 64'(0));
    endtask

    Op_st op_f;

    initial begin
        reset_n      = 1'b0;
        clk_en       = 1'b1;
        err_clr      = 1'b0;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        pr_if.tready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // single G00(100,100), processor acks after 3 cycles, done 20 later
        trig_hi = 0;
        push(mk(0, 100, 100));
        wait_idle(200);
        chk("t1_trig_len", 64'(trig_hi), 64'(3));
        chk("t1_busy_lag", 64'(busy_fall_t - rdy_rise_t), 64'(1));

        // fill FIFO while processor is busy; 5th push dropped
        p_hold = 1'b1;
        pr_if.tready = 1'b0;
        issued.delete();
        for (int i = 0; i < 4; i++) push(mk(1, 10 + i, 20 + i));
        chk("t2_count", 64'(count), 64'(4));
        chk("t2_in_rdy", 64'(in_if.tready), 64'(0));
        in_if.tvalid = 1'b1;
        in_if.tdata  = mk(1, 99, 99);
        tick();
        tick();
        chk("t2_drop", 64'(count), 64'(4));

        // release with a simultaneous push into the full FIFO
        op_f = mk(2, 555, 777);
        in_if.tdata  = op_f;
        pr_if.tready = 1'b1;
        p_hold = 1'b0;
        p_cnt  = 0;
        p_ack  = 2;
        p_done = 3;
        tick();
        in_if.tvalid = 1'b0;
        chk("t3_count", 64'(count), 64'(4));
        wait_idle(300);
        chk("t3_issued_n", 64'(issued.size()), 64'(5));
        chk("t3_last", 64'(issued[issued.size() - 1]), 64'(op_f));

        // ack timeout, then err_clr lets the queued op issue
        p_never = 1'b1;
        push(mk(0, 1, 2));
        push(mk(1, 3, 4));
        for (int i = 0; i < ACK + 20 && !m_err; i++) tick();
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_trigger", 64'(pr_if.tvalid), 64'(0));
        chk("t4_err_time", 64'(err_rise_t - trig_rise_t), 64'(ACK));
        p_never = 1'b0;
        issued.delete();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        wait_idle(200);
        chk("t4_next", 64'(issued[0]), 64'(mk(1, 3, 4)));

        // async reset in WAIT_DONE with two ops queued
        p_ack  = 1;
        p_done = 30;
        push(mk(0, 5, 5));
        push(mk(0, 6, 6));
        push(mk(0, 7, 7));
        for (int i = 0; i < 50 && !((m_ph == P_WAIT) && (m_q.size() == 2)); i++) tick();
        chk("t5_pre_count", 64'(count), 64'(2));
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t5_trigger", 64'(pr_if.tvalid), 64'(0));
        chk("t5_count",   64'(count),        64'(0));
        chk("t5_op",      64'(pr_if.tdata),  64'(0));
        chk("t5_busy",    64'(busy),         64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        pr_if.tready = 1'b1;
        p_cnt = 0;
        prev_trig = 1'b0;
        prev_busy = 1'b0;
        issued.delete();
        repeat (10) tick();
        chk("t5_no_issue", 64'(issued.size()), 64'(0));
        p_ack  = 3;
        p_done = 20;
        push(mk(3, 8, 8));
        wait_idle(200);

        // test 1 again with clk_en at 50%
        en_mode = 1;
        trig_hi = 0;
        push(mk(0, 100, 100));
        wait_idle(400);
        chk("t6_trig_len", 64'(trig_hi), 64'(6));

        // randomized traffic
        en_mode = 2;
        for (int i = 0; i < 600; i++) begin
            in_if.tvalid = 1'($urandom_range(0, 1));
            in_if.tdata  = mk($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) begin
                p_ack  = $urandom_range(1, 4);
                p_done = $urandom_range(1, 6);
            end
            tick();
        end
        in_if.tvalid = 1'b0;
        wait_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
